// File: rtl/fabric_mxn.sv
// rtl/fabric_mxn.sv - M-master by N-port OCP crossbar with per-port round-robin arbitration
//
// Ports:
//   clk, nrst                       clock, asynchronous active-low reset
//   i_M_MAddr/MCmd/MData/MByteEn    per-master request, master k in slice k
//   o_M_SCmdAccept/SData/SResp      per-master accept and response
//   o_P_MAddr/MCmd/MData/MByteEn    per-port request toward the device
//   i_P_SCmdAccept/SData/SResp      per-port accept and response from the device
module fabric_mxn #(
    parameter int NMASTERS   = 2,
    parameter int NPORTS     = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4,
    parameter int DEV_LSB    = 20,
    parameter int DEV_BITS   = 4
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [NMASTERS*ADDR_WIDTH-1:0] i_M_MAddr,
    input  logic [NMASTERS*3-1:0]          i_M_MCmd,
    input  logic [NMASTERS*DATA_WIDTH-1:0] i_M_MData,
    input  logic [NMASTERS*BEN_WIDTH-1:0]  i_M_MByteEn,
    output logic [NMASTERS-1:0]            o_M_SCmdAccept,
    output logic [NMASTERS*DATA_WIDTH-1:0] o_M_SData,
    output logic [NMASTERS*2-1:0]          o_M_SResp,
    output logic [NPORTS*ADDR_WIDTH-1:0]   o_P_MAddr,
    output logic [NPORTS*3-1:0]            o_P_MCmd,
    output logic [NPORTS*DATA_WIDTH-1:0]   o_P_MData,
    output logic [NPORTS*BEN_WIDTH-1:0]    o_P_MByteEn,
    input  logic [NPORTS-1:0]              i_P_SCmdAccept,
    input  logic [NPORTS*DATA_WIDTH-1:0]   i_P_SData,
    input  logic [NPORTS*2-1:0]            i_P_SResp
);

    localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int IW = DEV_BITS + 1;
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic {P_IDLE, P_BUSY} pstate_t;

    logic [IW-1:0]       dev_idx [NMASTERS];
    logic [NMASTERS-1:0] cmd_v, dec_err, m_busy, m_req, err_pend, err_nxt;

    pstate_t       state_q [NPORTS];
    pstate_t       state_d [NPORTS];
    logic [MW-1:0] owner_q [NPORTS];
    logic [MW-1:0] owner_d [NPORTS];
    logic [MW-1:0] ptr_q   [NPORTS];
    logic [MW-1:0] ptr_d   [NPORTS];
    logic [MW-1:0] gnt_m   [NPORTS];
    logic [MW-1:0] sel     [NPORTS];
    logic [NPORTS-1:0] acc_q, acc_d, rel_q, rel_d, gnt_v, drive;

    // Master-side decode. A master is busy while it owns a port or while its
    // decode-error response is pending, so it never has two transactions open.
    always_comb begin
        cmd_v   = '0;
        dec_err = '0;
        m_busy  = '0;
        m_req   = '0;
        err_nxt = '0;
        for (int k = 0; k < NMASTERS; k++) begin
            dev_idx[k] = '0;
            if (i_M_MAddr[k*ADDR_WIDTH + ADDR_WIDTH-1])
                dev_idx[k] = {1'b0, i_M_MAddr[k*ADDR_WIDTH + DEV_LSB +: DEV_BITS]} + IW'(1);
            cmd_v[k]   = nrst && (i_M_MCmd[k*3 +: 3] != CMD_IDLE);
            dec_err[k] = int'(dev_idx[k]) >= NPORTS;
            m_busy[k]  = err_pend[k];
            for (int p = 0; p < NPORTS; p++)
                if (state_q[p] == P_BUSY && int'(owner_q[p]) == k)
                    m_busy[k] = 1'b1;
            m_req[k]   = cmd_v[k] && !m_busy[k] && !dec_err[k];
            err_nxt[k] = cmd_v[k] && !m_busy[k] && dec_err[k];
        end
    end

    // Per-port arbitration and FSM next state. rel_q blocks a grant in the
    // cycle right after a release, giving the one-cycle bubble.
    always_comb begin
        int m;
        m     = 0;
        gnt_v = '0;
        drive = '0;
        acc_d = acc_q;
        rel_d = '0;
        for (int p = 0; p < NPORTS; p++) begin
            gnt_m[p]   = '0;
            state_d[p] = state_q[p];
            owner_d[p] = owner_q[p];
            ptr_d[p]   = ptr_q[p];
            if (state_q[p] == P_IDLE && !rel_q[p]) begin
                for (int i = 0; i < NMASTERS; i++) begin
                    m = int'(ptr_q[p]) + i;
                    if (m >= NMASTERS)
                        m = m - NMASTERS;
                    if (!gnt_v[p] && m_req[m] && int'(dev_idx[m]) == p) begin
                        gnt_v[p] = 1'b1;
                        gnt_m[p] = MW'(m);
                    end
                end
            end
            drive[p] = gnt_v[p] || (state_q[p] == P_BUSY && !acc_q[p]);
            sel[p]   = gnt_v[p] ? gnt_m[p] : owner_q[p];
            case (state_q[p])
                P_IDLE: begin
                    if (gnt_v[p]) begin
                        state_d[p] = P_BUSY;
                        owner_d[p] = gnt_m[p];
                        acc_d[p]   = i_P_SCmdAccept[p];
                    end
                end
                P_BUSY: begin
                    if (i_P_SResp[p*2 +: 2] != RESP_NULL) begin
                        state_d[p] = P_IDLE;
                        acc_d[p]   = 1'b0;
                        rel_d[p]   = 1'b1;
                        ptr_d[p]   = (int'(owner_q[p]) == NMASTERS-1) ? '0 : owner_q[p] + MW'(1);
                    end else if (drive[p] && i_P_SCmdAccept[p]) begin
                        acc_d[p] = 1'b1;
                    end
                end
                default: state_d[p] = P_IDLE;
            endcase
        end
    end

    // Zero-cycle forwarding of requests to ports and responses to owners.
    always_comb begin
        o_P_MAddr      = '0;
        o_P_MCmd       = '0;
        o_P_MData      = '0;
        o_P_MByteEn    = '0;
        o_M_SCmdAccept = err_nxt;
        o_M_SData      = '0;
        o_M_SResp      = '0;
        for (int k = 0; k < NMASTERS; k++)
            if (err_pend[k])
                o_M_SResp[k*2 +: 2] = RESP_ERR;
        for (int p = 0; p < NPORTS; p++) begin
            if (drive[p]) begin
                o_P_MAddr[p*ADDR_WIDTH +: ADDR_WIDTH]  = i_M_MAddr[int'(sel[p])*ADDR_WIDTH +: ADDR_WIDTH];
                o_P_MCmd[p*3 +: 3]                     = i_M_MCmd[int'(sel[p])*3 +: 3];
                o_P_MData[p*DATA_WIDTH +: DATA_WIDTH]  = i_M_MData[int'(sel[p])*DATA_WIDTH +: DATA_WIDTH];
                o_P_MByteEn[p*BEN_WIDTH +: BEN_WIDTH]  = i_M_MByteEn[int'(sel[p])*BEN_WIDTH +: BEN_WIDTH];
                o_M_SCmdAccept[sel[p]]                 = i_P_SCmdAccept[p];
            end
            if (state_q[p] == P_BUSY) begin
                o_M_SResp[int'(owner_q[p])*2 +: 2]                 = i_P_SResp[p*2 +: 2];
                o_M_SData[int'(owner_q[p])*DATA_WIDTH +: DATA_WIDTH] = i_P_SData[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p] <= P_IDLE;
                owner_q[p] <= '0;
                ptr_q[p]   <= '0;
            end
            acc_q    <= '0;
            rel_q    <= '0;
            err_pend <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p] <= state_d[p];
                owner_q[p] <= owner_d[p];
                ptr_q[p]   <= ptr_d[p];
            end
            acc_q    <= acc_d;
            rel_q    <= rel_d;
            err_pend <= err_nxt;
        end
    end

endmodule

// File: doc/fabric_mxn.md
FABRIC_MXN -- requirements
Module: fabric_mxn

Interface
REQ-001 Parameter NMASTERS, default 2, number of OCP master (CPU-side) ports.
REQ-002 Parameter NPORTS, default 5, number of OCP slave (device-side) ports, range 2..17.
REQ-003 Parameter ADDR_WIDTH, default 32, address width.
REQ-004 Parameter DATA_WIDTH, default 32, data width.
REQ-005 Parameter BEN_WIDTH, default 4, byte-enable width.
REQ-006 Parameter DEV_LSB, default 20, LSB of the device-select field.
REQ-007 Parameter DEV_BITS, default 4, width of the device-select field.
REQ-008 clk  input  1  single clock, all state on rising edge.
REQ-009 nrst  input  1  asynchronous, active-low reset.
REQ-010 i_M_MAddr  input  NMASTERS*ADDR_WIDTH  master addresses; master k occupies slice k.
REQ-011 i_M_MCmd  input  NMASTERS*3  master commands: IDLE=0, WR=1, RD=2.
REQ-012 i_M_MData  input  NMASTERS*DATA_WIDTH  master write data.
REQ-013 i_M_MByteEn  input  NMASTERS*BEN_WIDTH  master byte enables.
REQ-014 o_M_SCmdAccept  output  NMASTERS  command accepted, per master.
REQ-015 o_M_SData  output  NMASTERS*DATA_WIDTH  read data, per master.
REQ-016 o_M_SResp  output  NMASTERS*2  response, per master: NULL=0, DVA=1, ERR=3.
REQ-017 o_P_MAddr, o_P_MCmd, o_P_MData, o_P_MByteEn  outputs  NPORTS*(ADDR_WIDTH, 3, DATA_WIDTH, BEN_WIDTH)  per-port request.
REQ-018 i_P_SCmdAccept, i_P_SData, i_P_SResp  inputs  NPORTS*(1, DATA_WIDTH, 2)  per-port response.

Function
REQ-019 Decode SHALL be: addr[ADDR_WIDTH-1]=0 -> port 0; addr[ADDR_WIDTH-1]=1 -> port 1+addr[DEV_LSB+DEV_BITS-1:DEV_LSB].
REQ-020 A decoded index >= NPORTS SHALL be a decode error.
REQ-021 Each port SHALL own an FSM with two states: IDLE and BUSY(owner).
- IDLE -> BUSY on a grant.
- BUSY -> IDLE on the cycle its i_P_SResp != NULL.
REQ-022 A port in IDLE SHALL grant, combinationally in the same cycle, one requesting master (MCmd != IDLE, decoded to that port), chosen round-robin starting at that port's priority pointer.
REQ-023 A granted master's MAddr/MCmd/MData/MByteEn SHALL be driven on the port while the port is in BUSY(owner) or is being granted, and until the slave asserts SCmdAccept; after acceptance the port SHALL drive MCmd=IDLE.
REQ-024 o_M_SCmdAccept[k] SHALL equal the granted port's i_P_SCmdAccept while master k holds the grant, and 0 otherwise; a master that is not granted is stalled and holds its command.
REQ-025 o_M_SResp/o_M_SData of master k SHALL mirror the port it owns; otherwise SResp SHALL be NULL and SData SHALL be 0.
REQ-026 On release, the port's priority pointer SHALL become (owner+1) mod NMASTERS.
REQ-027 A freed port SHALL not regrant in its release cycle; there is a one-cycle bubble.
REQ-028 Different ports SHALL serve different masters concurrently with no added latency; forwarding is zero-cycle combinational.
REQ-029 Each master SHALL have at most one outstanding transaction.
REQ-030 On a decode error:
- SCmdAccept=1 in the command cycle;
- next cycle, SResp=ERR and SData=0 for exactly one cycle;
- no port sees the command.
REQ-031 A master that issues a new command on its response cycle SHALL be arbitrated normally from the next cycle.

Reset
REQ-032 While nrst=0, the fabric SHALL force:
- all o_P_MCmd=IDLE; o_P_MAddr/MData/MByteEn=0;
- o_M_SCmdAccept=0; o_M_SResp=NULL; o_M_SData=0;
- all port FSMs=IDLE; all priority pointers=0; decode-error flags cleared.
REQ-033 Reset asserted mid-transaction SHALL drop all grants immediately; late slave responses after reset SHALL be discarded.

Verification
REQ-034 Reset -> with nrst=0 and random master stimulus, every port MCmd=0 and every master SResp=0.
REQ-035 M0 WR 0x0000_0004 data F1F2F3F4, then RD 0x0000_0004 -> port 0 sees WR then RD; M0 gets DVA twice; read data is F1F2F3F4; M1 sees SResp=NULL throughout.
REQ-036 M0 and M1 both WR 0x8000_0000 in the same cycle -> M0 is granted (pointer 0) and M1 is stalled with SCmdAccept=0; M1 is granted two cycles after M0's DVA (one-cycle bubble); a repeated conflict then grants M1 first.
REQ-037 M0 RD 0x8020_0004 and M1 RD 0x8030_0008 in the same cycle -> both commands appear on ports 3 and 4 in that same cycle, with no stall.
REQ-038 With NPORTS=5, M1 RD 0x8070_0000 -> SCmdAccept=1 that cycle, SResp=3 with SData=0 the next cycle, and all port MCmd remain 0.
REQ-039 nrst pulsed low while port 0 is BUSY -> port 0 is freed and M0 SResp=0; a fresh M1 request after reset is granted normally.
